uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter letting NREQ requesters share one UART transmitter.
// Define UART_TX_ARB_TIMEOUT_EN to abandon frames whose tx_done never arrives.
module uart_tx_arbiter #(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_i,
    input  logic [NREQ*DATA_W-1:0]    req_data_i,
    output logic [NREQ-1:0]           ack_o,
    output logic [$clog2(NREQ)-1:0]   grant_id_o,
    output logic                      busy_o,
    output logic                      tx_load_o,
    output logic [DATA_W-1:0]         tx_data_o,
    input  logic                      tx_done_i,
    output logic                      timeout_err_o
);

    localparam int unsigned GW = $clog2(NREQ);

    typedef enum logic [1:0] {
        ArbIdle,
        ArbLoad,
        ArbWait,
        ArbRelease
    } state_e;

    state_e            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     last_grant_q, last_grant_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [GW-1:0]     winner;
    logic [GW-1:0]     rr_idx;
    logic              found;
    logic [DATA_W-1:0] sel_data;
    logic              timeout_hit;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            to_err_q, to_err_d;

    // cnt_q holds the number of completed ARB_WAIT cycles.
    assign timeout_hit = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d    = '0;
        to_err_d = 1'b0;
        if (state_q == ArbWait) begin
            cnt_d    = cnt_q + 1'b1;
            to_err_d = !tx_done_i && timeout_hit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            to_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            to_err_q <= to_err_d;
        end
    end

    assign timeout_err_o = to_err_q;
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout_hit           = 1'b0;
    assign timeout_err_o         = 1'b0;
`endif

    // Search upward from the slot after the last grant; first pending request wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        rr_idx = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            rr_idx = GW'((32'(last_grant_q) + k) % NREQ);
            if (!found && req_i[rr_idx]) begin
                found  = 1'b1;
                winner = rr_idx;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (winner == GW'(i)) begin
                sel_data = req_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        case (state_q)
            ArbIdle: begin
                if (found) begin
                    grant_d = winner;
                    data_d  = sel_data;
                    state_d = ArbLoad;
                end
            end
            ArbLoad: state_d = ArbWait;
            ArbWait: begin
                if (tx_done_i || timeout_hit) begin
                    state_d = ArbRelease;
                end
            end
            ArbRelease: begin
                last_grant_d = grant_q;
                state_d      = ArbIdle;
            end
            default: state_d = ArbIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ArbIdle;
            grant_q      <= '0;
            last_grant_q <= GW'(NREQ - 1);
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
        end
    end

    always_comb begin
        ack_o = '0;
        if (state_q == ArbLoad) begin
            ack_o[grant_q] = 1'b1;
        end
    end

    assign tx_load_o  = (state_q == ArbLoad);
    assign busy_o     = (state_q != ArbIdle);
    assign grant_id_o = grant_q;
    assign tx_data_o  = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants are queued by the stimulus
// and popped by a monitor on every tx_load pulse.
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned TO     = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  ack;
    logic [1:0]  grant_id;
    logic        busy;
    logic        tx_load;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;
    logic        timeout_err;

    uart_tx_arbiter #(
        .NREQ          (NREQ),
        .DATA_W        (DATA_W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req),
        .req_data_i   (req_data),
        .ack_o        (ack),
        .grant_id_o   (grant_id),
        .busy_o       (busy),
        .tx_load_o    (tx_load),
        .tx_data_o    (tx_data),
        .tx_done_i    (tx_done),
        .timeout_err_o(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int         g;
        logic [7:0] d;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_grant(input int g, input logic [7:0] d);
        exp_t e;
        e.g = g;
        e.d = d;
        sb.push_back(e);
    endtask

    // Monitor: every tx_load must match the oldest queued expectation.
    exp_t mon_e;
    logic prev_load = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            if (tx_load) begin
                check("load_pulse_width", {31'b0, prev_load}, 0);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_load: got grant %0d data 0x%0h, want no load",
                             grant_id, tx_data);
                end else begin
                    mon_e = sb.pop_front();
                    check("grant_id", {30'b0, grant_id}, mon_e.g);
                    check("tx_data", {24'b0, tx_data}, {24'b0, mon_e.d});
                    check("ack_onehot", {28'b0, ack}, 32'(1) << mon_e.g);
                end
            end else begin
                check("ack_idle", {28'b0, ack}, 0);
            end
        end
        prev_load <= tx_load;
    end

    task automatic wait_load(output int c);
        int n = 0;
        while (tx_load !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (tx_load !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_load: tx_load got 0 within 50 cycles, want 1");
        end
        c = cyc;
    endtask

    // Waits for the load, optionally drops req[g], then pulses tx_done done_delay cycles later.
    task automatic serve(input int g, input bit drop, input int done_delay, output int lc);
        wait_load(lc);
        if (drop) req[g] = 1'b0;
        repeat (done_delay) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

    int lc, prev_lc;
    int pulses, at, bad_busy, bad_err;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack", {28'b0, ack}, 0);
        check("rst_tx_load", {31'b0, tx_load}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_timeout_err", {31'b0, timeout_err}, 0);
        check("rst_tx_data", {24'b0, tx_data}, 0);
        check("rst_grant_id", {30'b0, grant_id}, 0);

        // Single request sampled on the first edge after reset release
        req_data = {8'h03, 8'h02, 8'h01, 8'hA5};
        expect_grant(0, 8'hA5);
        rst = 1'b1;
        req = 4'b0001;
        @(negedge clk);
        check("first_req_load", {31'b0, tx_load}, 1);
        wait_load(lc);
        req = 4'b0000;
        req_data[7:0] = 8'h5A;
        repeat (10) @(negedge clk);
        check("tx_data_stable", {24'b0, tx_data}, 32'hA5);
        check("busy_in_wait", {31'b0, busy}, 1);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("busy_release", {31'b0, busy}, 1);
        @(negedge clk);
        check("busy_idle", {31'b0, busy}, 0);

        // Fairness from a fresh reset, all requests held
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) expect_grant(k % 4, 8'(8'h10 + (k % 4)));
        prev_lc = 0;
        for (int k = 0; k < 5; k++) begin
            serve(k % 4, 1'b0, 1, lc);
            if (k > 0) check("load_spacing", lc - prev_lc, 4);
            prev_lc = lc;
            if (k == 4) req = 4'b0000;
        end
        @(negedge clk);
        check("fair_idle", {31'b0, busy}, 0);

        // Wrap: grant 2 first, then 0011 -> 0 then 1
        req_data = {8'h33, 8'h32, 8'h31, 8'h30};
        expect_grant(2, 8'h32);
        req = 4'b0100;
        serve(2, 1'b1, 3, lc);
        expect_grant(0, 8'h30);
        expect_grant(1, 8'h31);
        req = 4'b0011;
        serve(0, 1'b1, 1, lc);
        serve(1, 1'b1, 1, lc);
        @(negedge clk);

        // Reset during ARB_WAIT
        expect_grant(2, 8'h32);
        req = 4'b0100;
        wait_load(lc);
        req = 4'b0000;
        @(negedge clk);
        check("grant_before_rst", {30'b0, grant_id}, 2);
        #2 rst = 1'b0;
        #1;
        check("arst_ack", {28'b0, ack}, 0);
        check("arst_tx_load", {31'b0, tx_load}, 0);
        check("arst_busy", {31'b0, busy}, 0);
        check("arst_grant_id", {30'b0, grant_id}, 0);
        check("arst_tx_data", {24'b0, tx_data}, 0);
        check("arst_timeout_err", {31'b0, timeout_err}, 0);
        @(negedge clk);
        rst = 1'b1;
        expect_grant(2, 8'h32);
        req = 4'b0100;
        @(negedge clk);
        check("regrant_load", {31'b0, tx_load}, 1);
        serve(2, 1'b1, 1, lc);
        @(negedge clk);

        // Stray tx_done in ARB_IDLE and ARB_LOAD; short-lived req[1] during the frame
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("stray_idle_busy", {31'b0, busy}, 0);
        expect_grant(3, 8'h33);
        req = 4'b1000;
        tx_done = 1'b1;
        @(negedge clk);
        check("stray_load", {31'b0, tx_load}, 1);
        req = 4'b0000;
        @(negedge clk);
        tx_done = 1'b0;
        req = 4'b0010;
        repeat (2) @(negedge clk);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        check("stray_still_wait", {31'b0, busy}, 1);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("stray_release", {31'b0, busy}, 1);
        @(negedge clk);
        check("stray_idle", {31'b0, busy}, 0);

        // Missing tx_done
        expect_grant(0, 8'h30);
        req = 4'b0001;
        wait_load(lc);
        req = 4'b0000;
`ifdef UART_TX_ARB_TIMEOUT_EN
        pulses = 0;
        at     = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (timeout_err) begin
                pulses++;
                if (at < 0) at = cyc - lc;
            end
        end
        check("timeout_pulses", pulses, 1);
        check("timeout_delay", at, TO + 1);
        check("timeout_idle", {31'b0, busy}, 0);
`else
        bad_busy = 0;
        bad_err  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) bad_busy++;
            if (timeout_err) bad_err++;
        end
        check("no_timeout_busy_drops", bad_busy, 0);
        check("no_timeout_err", bad_err, 0);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        @(negedge clk);
        check("late_done_idle", {31'b0, busy}, 0);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
